aes_decrypt_core: RTL and testbench

Iterative AES-128 inverse cipher: accepts one 128-bit ciphertext block over a valid/ready handshake, runs the FIPS-197 inverse cipher one round per clock, and presents the plaintext block over a second valid/ready handshake. It is the decrypt-direction counterpart of the encrypt round datapath. It reuses the combinational invShiftRows, invSubBytes and invMixColumns submodules (128-bit `state` in, `out` out). Round keys come from an external key store through an indexed lookup port.

---
 rtl/aes_decrypt_core.sv | 221 ++++++++++++++++++++++
 tb/tb_aes_decrypt_core.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher, one round per clock, with valid/ready on both sides.
// Optional CBC chaining is compiled in with `define AES_DEC_CBC_EN; the default build is ECB.

package aes_dec_pkg;
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = a;
        e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction
endpackage

module invShiftRows (
    input  logic [127:0] state,
    output logic [127:0] out
);
    always_comb begin
        out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                out[127-8*(4*c+r) -: 8] = state[127-8*(4*((c+4-r)%4)+r) -: 8];
            end
        end
    end
endmodule

module invSubBytes (
    input  logic [127:0] state,
    output logic [127:0] out
);
    always_comb begin
        out = '0;
        for (int i = 0; i < 16; i++) begin
            out[8*i +: 8] = aes_dec_pkg::inv_sbox(state[8*i +: 8]);
        end
    end
endmodule

module invMixColumns (
    input  logic [127:0] state,
    output logic [127:0] out
);
    import aes_dec_pkg::gf_mul;
    logic [7:0] a0, a1, a2, a3;

    always_comb begin
        out = '0;
        a0  = '0;
        a1  = '0;
        a2  = '0;
        a3  = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = state[127-32*c -: 8];
            a1 = state[119-32*c -: 8];
            a2 = state[111-32*c -: 8];
            a3 = state[103-32*c -: 8];
            out[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            out[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            out[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            out[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
    end
endmodule

module aes_decrypt_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   key_idx,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
`ifdef AES_DEC_CBC_EN
    ,
    input  logic         iv_load,
    input  logic [127:0] iv
`endif
);
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] LAST_KEY = CNT_W'(10);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [BLK_W-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   key_idx_q, key_idx_d;
`ifdef AES_DEC_CBC_EN
    logic [BLK_W-1:0]   chain_q, chain_d;
    logic [BLK_W-1:0]   hold_q, hold_d;
`endif

    logic [BLK_W-1:0]   sr_out, sb_out, ark, mc_out;

    invShiftRows  u_isr (.state(blk_q), .out(sr_out));
    invSubBytes   u_isb (.state(sr_out), .out(sb_out));
    assign ark = sb_out ^ round_key;
    invMixColumns u_imc (.state(ark), .out(mc_out));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            blk_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            key_idx_q   <= LAST_KEY;
`ifdef AES_DEC_CBC_EN
            chain_q     <= '0;
            hold_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            blk_q       <= blk_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            key_idx_q   <= key_idx_d;
`ifdef AES_DEC_CBC_EN
            chain_q     <= chain_d;
            hold_q      <= hold_d;
`endif
        end
    end

    // in_ready and key_idx are registered copies of what the next state implies.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        blk_d       = blk_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef AES_DEC_CBC_EN
        chain_d     = chain_q;
        hold_d      = hold_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef AES_DEC_CBC_EN
                if (iv_load) chain_d = iv;
`endif
                if (in_valid && in_ready_q) begin
                    blk_d   = in_data ^ round_key;
                    cnt_d   = CNT_W'(9);
                    state_d = ROUND;
`ifdef AES_DEC_CBC_EN
                    hold_d  = in_data;
`endif
                end
            end
            ROUND: begin
                if (cnt_q != '0) begin
                    blk_d = mc_out;
                    cnt_d = CNT_W'(cnt_q - CNT_W'(1));
                end else begin
`ifdef AES_DEC_CBC_EN
                    out_data_d = ark ^ chain_q;
                    chain_d    = hold_q;
`else
                    out_data_d = ark;
`endif
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
        key_idx_d  = (state_d == ROUND) ? cnt_d : LAST_KEY;
    end

    assign in_ready  = in_ready_q;
    assign key_idx   = key_idx_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed FIPS-197 / SP800-38A vectors for aes_decrypt_core with a bench-side key schedule.
// CBC checks compile in when AES_DEC_CBC_EN is defined.

module tb_aes_decrypt_core;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [3:0]   key_idx;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
`ifdef AES_DEC_CBC_EN
    logic         iv_load = 1'b0;
    logic [127:0] iv = '0;
`endif

    logic [127:0] rk [0:10];
    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;

    aes_decrypt_core dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .key_idx(key_idx), .round_key(round_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef AES_DEC_CBC_EN
        , .iv_load(iv_load), .iv(iv)
`endif
    );

    always_comb begin
        round_key = '0;
        if (key_idx <= 4'd10) round_key = rk[key_idx];
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] tb_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = tb_xtime(x);
        end
        return p;
    endfunction

    // Forward S-box from a brute-force inverse search plus the forward affine map.
    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [7:0] v = '0;
        for (int y = 1; y < 256; y++) begin
            if (x != 8'h00 && tb_mul(x, 8'(y)) == 8'h01) v = 8'(y);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])} ^ {rcon, 24'h0};
                rcon = tb_xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check_eq({tag, "_in_ready"},  128'(in_ready),  128'(1));
        check_eq({tag, "_key_idx"},   128'(key_idx),   128'(10));
    endtask

    // One block: accept, round-by-round key_idx check, optional output stall, drain.
    task automatic do_block(input logic [127:0] ct, input logic [127:0] pt, input int stall, input bit iv_pulse);
        @(negedge clk);
        out_ready = (stall == 0);
        check_eq("acc_in_ready", 128'(in_ready), 128'(1));
        check_eq("acc_key_idx", 128'(key_idx), 128'(10));
        in_valid = 1'b1;
        in_data  = ct;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~ct;
        for (int k = 0; k < 10; k++) begin
            check_eq("round_key_idx", 128'(key_idx), 128'(9 - k));
            check_eq("round_out_valid", 128'(out_valid), 128'(0));
            check_eq("round_in_ready", 128'(in_ready), 128'(0));
`ifdef AES_DEC_CBC_EN
            if (iv_pulse) begin
                iv_load = (k == 3);
                iv      = {4{32'hdeadbeef}};
            end
`endif
            @(negedge clk);
        end
`ifdef AES_DEC_CBC_EN
        iv_load = 1'b0;
`endif
        check_eq("done_out_valid", 128'(out_valid), 128'(1));
        check_eq("done_out_data", out_data, pt);
        check_eq("done_key_idx", 128'(key_idx), 128'(10));
        for (int i = 0; i < stall; i++) begin
            in_valid = i[0];
            in_data  = {4{$urandom}};
            check_eq("stall_out_valid", 128'(out_valid), 128'(1));
            check_eq("stall_out_data", out_data, pt);
            check_eq("stall_in_ready", 128'(in_ready), 128'(0));
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_idle("drain");
    endtask

    initial begin
        int n_acc;
        int n_out;
        int acc_at [2];
        set_key(KEY_C1);
        repeat (2) @(negedge clk);
        check_eq("rst_out_data", out_data, 128'(0));
        check_idle("rst");
        rst = 1'b0;

        do_block(CT_C1, PT_C1, 0, 1'b0);
        do_block(CT_C1, PT_C1, 20, 1'b0);

        // Back-to-back with in_valid held high.
        n_acc = 0;
        n_out = 0;
        acc_at[0] = 0;
        acc_at[1] = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = CT_C1;
        for (int s = 0; s < 24; s++) begin
            if (in_ready) begin
                if (n_acc < 2) acc_at[n_acc] = s;
                n_acc++;
            end
            if (out_valid) begin
                n_out++;
                check_eq("b2b_out_data", out_data, PT_C1);
            end
            if (s == 23) in_valid = 1'b0;
            @(negedge clk);
        end
        check_eq("b2b_accepts", 128'(n_acc), 128'(2));
        check_eq("b2b_outputs", 128'(n_out), 128'(2));
        check_eq("b2b_gap", 128'(acc_at[1] - acc_at[0]), 128'(12));

        // Reset while the block is in round 5.
        in_valid = 1'b1;
        in_data  = CT_C1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_out_data", out_data, 128'(0));
        check_idle("midrst");
        n_out = 0;
        for (int s = 0; s < 15; s++) begin
            if (out_valid) n_out++;
            @(negedge clk);
        end
        check_eq("midrst_no_output", 128'(n_out), 128'(0));
        do_block(CT_C1, PT_C1, 0, 1'b0);

`ifdef AES_DEC_CBC_EN
        set_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        @(negedge clk);
        iv_load = 1'b1;
        iv      = 128'h000102030405060708090a0b0c0d0e0f;
        @(negedge clk);
        iv_load = 1'b0;
        do_block(128'h7649abac8119b246cee98e9b12e9197d, 128'h6bc1bee22e409f96e93d7e117393172a, 0, 1'b0);
        do_block(128'h5086cb9b507219ee95db113a917678b2, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 0, 1'b0);
        @(negedge clk);
        iv_load = 1'b1;
        iv      = 128'h000102030405060708090a0b0c0d0e0f;
        @(negedge clk);
        iv_load = 1'b0;
        do_block(128'h7649abac8119b246cee98e9b12e9197d, 128'h6bc1bee22e409f96e93d7e117393172a, 0, 1'b1);
        do_block(128'h5086cb9b507219ee95db113a917678b2, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
